// File: rtl/up_down_cnt_pkg.sv
// Shared width and count type for the up/down counter and anything that
// consumes its output.
package up_down_cnt_pkg;

    localparam int CNT_WIDTH = 4;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/up_down_cnt.sv
// Wrapping binary up/down counter with enable and parallel load; the count
// output is a register with no combinational path from the inputs.
module up_down_cnt
    import up_down_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_next;

    // Load beats counting; both directions wrap naturally at WIDTH bits.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = count_in;
        end else if (en) begin
            if (up) begin
                count_next = count + WIDTH'(1);
            end else begin
                count_next = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_up_down_cnt.sv
// Directed bench for up_down_cnt at WIDTH=4: inputs change on the falling
// edge, count is sampled 1 time unit after each rising edge.
module tb_up_down_cnt;
    import up_down_cnt_pkg::*;

    logic clk;
    logic rst;
    logic en;
    logic up;
    logic load;
    cnt_t count_in;
    cnt_t count;

    int compared;
    int mismatched;

    up_down_cnt #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .count_in (count_in),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input logic e, input logic u, input logic l, input cnt_t ci);
        @(negedge clk);
        en       = e;
        up       = u;
        load     = l;
        count_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
    endtask

    task automatic test_reset();
        cnt_t exp;
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_initial: got %0d expected 0", count);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
            exp = cnt_t'(i);
            compared++;
            if (count !== exp) begin
                mismatched++;
                $display("[TB] FAIL reset_precount: got %0d expected %0d", count, exp);
            end
        end
        // Assert reset between edges: count must clear without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_async: got %0d expected 0", count);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
            compared++;
            if (count !== 4'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_held: got %0d expected 0", count);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got %0d expected 1", count);
        end
        for (int i = 2; i <= 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
            exp = cnt_t'(i);
            compared++;
            if (count !== exp) begin
                mismatched++;
                $display("[TB] FAIL reset_resume: got %0d expected %0d", count, exp);
            end
        end
    endtask

    task automatic test_up_wrap();
        cnt_t exp;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
            exp = (i == 16) ? 4'd0 : cnt_t'(i);
            compared++;
            if (count !== exp) begin
                mismatched++;
                $display("[TB] FAIL up_wrap: got %0d expected %0d", count, exp);
            end
        end
    endtask

    task automatic test_down_wrap();
        cnt_t exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 4'd0);
            exp = cnt_t'(15 - i);
            compared++;
            if (count !== exp) begin
                mismatched++;
                $display("[TB] FAIL down_wrap: got %0d expected %0d", count, exp);
            end
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b0, 1'b1, 4'd7);
        compared++;
        if (count !== 4'd7) begin
            mismatched++;
            $display("[TB] FAIL hold_preset: got %0d expected 7", count);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, logic'(i % 2), 1'b0, 4'd2);
            compared++;
            if (count !== 4'd7) begin
                mismatched++;
                $display("[TB] FAIL hold: got %0d expected 7", count);
            end
        end
    endtask

    task automatic test_load_priority();
        cycle(1'b0, 1'b0, 1'b1, 4'd3);
        compared++;
        if (count !== 4'd3) begin
            mismatched++;
            $display("[TB] FAIL load_preset: got %0d expected 3", count);
        end
        cycle(1'b1, 1'b1, 1'b1, 4'd10);
        compared++;
        if (count !== 4'd10) begin
            mismatched++;
            $display("[TB] FAIL load_over_en: got %0d expected 10", count);
        end
        cycle(1'b1, 1'b1, 1'b0, 4'd10);
        compared++;
        if (count !== 4'd11) begin
            mismatched++;
            $display("[TB] FAIL load_resume: got %0d expected 11", count);
        end
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        compared++;
        if (count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL load_zero: got %0d expected 0", count);
        end
        cycle(1'b1, 1'b0, 1'b1, 4'd15);
        compared++;
        if (count !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL load_over_down: got %0d expected 15", count);
        end
    endtask

    task automatic test_direction_change();
        cnt_t exp;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
            exp = cnt_t'(i);
            compared++;
            if (count !== exp) begin
                mismatched++;
                $display("[TB] FAIL dir_up: got %0d expected %0d", count, exp);
            end
        end
        for (int i = 4; i >= -1; i--) begin
            cycle(1'b1, 1'b0, 1'b0, 4'd0);
            exp = (i < 0) ? 4'd15 : cnt_t'(i);
            compared++;
            if (count !== exp) begin
                mismatched++;
                $display("[TB] FAIL dir_down: got %0d expected %0d", count, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b0, 1'b1, 4'd5);
        compared++;
        if (count !== 4'd5) begin
            mismatched++;
            $display("[TB] FAIL b2b_load1: got %0d expected 5", count);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'd9);
        compared++;
        if (count !== 4'd9) begin
            mismatched++;
            $display("[TB] FAIL b2b_load2: got %0d expected 9", count);
        end
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        compared++;
        if (count !== 4'd8) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: got %0d expected 8", count);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        en         = 1'b0;
        up         = 1'b0;
        load       = 1'b0;
        count_in   = 4'd0;

        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_hold();
        test_load_priority();
        test_direction_change();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
